// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the display path.
// Edit-mode encoding, digit-enable masks and divider calculations.
package display_pkg;

   typedef enum logic [1:0] {
      EDIT_NONE    = 2'b00,
      EDIT_HOURS   = 2'b01,
      EDIT_MINUTES = 2'b10,
      EDIT_ALL     = 2'b11
   } edit_mode_e;

   // Digit-enable bit order: bit 3 = Dig1 (leftmost) ... bit 0 = Dig4
   localparam logic [3:0] DIG_MASK_ALL     = 4'b1111;
   localparam logic [3:0] DIG_MASK_NONE    = 4'b0000;
   localparam logic [3:0] DIG_MASK_HOURS   = 4'b1100;
   localparam logic [3:0] DIG_MASK_MINUTES = 4'b0011;

   // Clock cycles per digit slot
   function automatic int scan_div(input int clk_hz, input int rate_hz);
      return clk_hz / rate_hz;
   endfunction

   // Clock cycles per blink phase (half of the full blink period)
   function automatic int blink_div(input int clk_hz, input int blink_hz);
      return clk_hz / (2 * blink_hz);
   endfunction

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: live digit/mode inputs and registered scan outputs
// between the scan stage and the 7-segment decoder.
// master = display_scan side, slave = the side supplying inputs and
// consuming outputs.
interface display_scan_if;

   logic [1:0] i_Edit_Mode;
   logic       i_Colon_Blink;
   logic [3:0] i_Data_Dig1;
   logic [3:0] i_Data_Dig2;
   logic [3:0] i_Data_Dig3;
   logic [3:0] i_Data_Dig4;

   logic [1:0] o_Select;
   logic [3:0] o_Enable_Digits;
   logic       o_Enable_Dot;
   logic [3:0] o_Data_Dig1;
   logic [3:0] o_Data_Dig2;
   logic [3:0] o_Data_Dig3;
   logic [3:0] o_Data_Dig4;
   logic       o_Frame_Start;

   modport master (
      input  i_Edit_Mode, i_Colon_Blink,
      input  i_Data_Dig1, i_Data_Dig2, i_Data_Dig3, i_Data_Dig4,
      output o_Select, o_Enable_Digits, o_Enable_Dot,
      output o_Data_Dig1, o_Data_Dig2, o_Data_Dig3, o_Data_Dig4,
      output o_Frame_Start
   );

   modport slave (
      output i_Edit_Mode, i_Colon_Blink,
      output i_Data_Dig1, i_Data_Dig2, i_Data_Dig3, i_Data_Dig4,
      input  o_Select, o_Enable_Digits, o_Enable_Dot,
      input  o_Data_Dig1, o_Data_Dig2, o_Data_Dig3, o_Data_Dig4,
      input  o_Frame_Start
   );

endinterface

// File: rtl/tick_div.sv
// tick_div: counts 0 .. DIV-1 and wraps, with a synchronous clear.
// tick is high during the terminal count; a clear suppresses it and
// restarts the count from zero on the next edge.
module tick_div #(
   parameter int DIV = 2,
   parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   output logic         tick,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LAST = W'(DIV - 1);

   assign tick = (count == LAST) && !clr;

   // Free-running count with wrap at the terminal value
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/display_scan.sv
// display_scan: digit multiplex select, blinking digit/dot enables and a
// frame-coherent BCD snapshot feeding the 7-segment decoder.
// Optional build macro DISPLAY_SCAN_BLANKING_EN: blank all enables for the
// first BLANK_CYCLES prescaler counts of every digit slot.
module display_scan
   import display_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 12_000_000,
   parameter int SCAN_RATE_HZ = 1000,
   parameter int BLINK_HZ     = 2,
   parameter int BLANK_CYCLES = 16
) (
   input  logic           i_Clk,
   input  logic           i_Reset,
   display_scan_if.master bus
);

   localparam int SCAN_DIV  = scan_div(CLK_FREQ_HZ, SCAN_RATE_HZ);
   localparam int BLINK_DIV = blink_div(CLK_FREQ_HZ, BLINK_HZ);
   localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SCAN_W-1:0] BLANK_LIM = SCAN_W'(BLANK_CYCLES);
`ifdef DISPLAY_SCAN_BLANKING_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic               scan_tick;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [SCAN_W-1:0]  scan_cnt_next;
   logic               blink_tick;
   logic [BLINK_W-1:0] blink_cnt_unused;

   logic [1:0] mode_q;
   logic       mode_change;
   logic       r_Visible;
   logic       vis_next;
   logic       r_Pending;
   logic       load;
   logic       blank;
   logic [3:0] mask_next;

   assign mode_change = (bus.i_Edit_Mode != mode_q);

   tick_div #(.DIV(SCAN_DIV), .W(SCAN_W)) u_scan_div (
      .clk   (i_Clk),
      .rst   (i_Reset),
      .clr   (1'b0),
      .tick  (scan_tick),
      .count (scan_cnt)
   );

   // A mode change restarts the blink phase so edited digits show at once
   tick_div #(.DIV(BLINK_DIV), .W(BLINK_W)) u_blink_div (
      .clk   (i_Clk),
      .rst   (i_Reset),
      .clr   (mode_change),
      .tick  (blink_tick),
      .count (blink_cnt_unused)
   );

   // Next-state values; enables are computed from them so the registered
   // enables line up with the registered visibility and slot position
   always_comb begin
      vis_next      = r_Visible;
      load          = r_Pending || (scan_tick && (bus.o_Select == 2'b11));
      scan_cnt_next = scan_tick ? '0 : scan_cnt + 1'b1;
      blank         = BLANK_ON && (scan_cnt_next < BLANK_LIM);
      if (mode_change) begin
         vis_next = 1'b1;
      end else if (blink_tick) begin
         vis_next = !r_Visible;
      end
   end

   // Digit mask: edited digits drop out during the hidden blink phase
   always_comb begin
      mask_next = DIG_MASK_ALL;
      if (!vis_next) begin
         case (edit_mode_e'(bus.i_Edit_Mode))
            EDIT_HOURS:   mask_next = DIG_MASK_ALL & ~DIG_MASK_HOURS;
            EDIT_MINUTES: mask_next = DIG_MASK_ALL & ~DIG_MASK_MINUTES;
            EDIT_ALL:     mask_next = DIG_MASK_NONE;
            default:      mask_next = DIG_MASK_ALL;
         endcase
      end
   end

   // Registered copy of the edit mode for change detection; it tracks the
   // input through reset so release does not look like a mode change
   always_ff @(posedge i_Clk) begin
      mode_q <= bus.i_Edit_Mode;
   end

   // Select, blink phase, enables and frame snapshot registers
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         bus.o_Select        <= 2'b00;
         bus.o_Enable_Digits <= DIG_MASK_NONE;
         bus.o_Enable_Dot    <= 1'b0;
         bus.o_Frame_Start   <= 1'b0;
         bus.o_Data_Dig1     <= 4'd0;
         bus.o_Data_Dig2     <= 4'd0;
         bus.o_Data_Dig3     <= 4'd0;
         bus.o_Data_Dig4     <= 4'd0;
         r_Visible           <= 1'b1;
         r_Pending           <= 1'b1;
      end else begin
         if (scan_tick) begin
            bus.o_Select <= bus.o_Select + 2'd1;
         end
         r_Visible           <= vis_next;
         r_Pending           <= 1'b0;
         bus.o_Frame_Start   <= load;
         bus.o_Enable_Digits <= blank ? DIG_MASK_NONE : mask_next;
         bus.o_Enable_Dot    <= blank ? 1'b0
                                      : (bus.i_Colon_Blink ? vis_next : 1'b1);
         if (load) begin
            bus.o_Data_Dig1 <= bus.i_Data_Dig1;
            bus.o_Data_Dig2 <= bus.i_Data_Dig2;
            bus.o_Data_Dig3 <= bus.i_Data_Dig3;
            bus.o_Data_Dig4 <= bus.i_Data_Dig4;
         end
      end
   end

endmodule
